// File: rtl/apb_slave_regfile.sv
// APB4 completer with a byte-strobed register file and fixed wait states.
// Address/data/strobes are captured at setup; outputs are all registered.
`timescale 1ns/1ps
module apb_slave_regfile #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int REG_IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W:0] NREGS_L = (IDX_W + 1)'(NUM_REGS);
    localparam logic [3:0]     WS_L    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic [REG_IW-1:0]     idx_q;
    logic                  err_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     strb_q;

    logic [IDX_W-1:0]      bus_idx;
    logic                  misal;
    logic                  bus_err;
    logic                  accept;
    logic                  enter_resp;
    logic                  leave;
    logic                  commit;
    logic [REG_IW-1:0]     sel_idx;
    logic                  sel_err;
    logic                  sel_write;
    logic [DATA_WIDTH-1:0] rd_val;

    assign bus_idx = PADDR[ADDR_WIDTH-1:ADDR_LSB];

    generate
        if (ADDR_LSB > 0) begin : g_align
            assign misal = |PADDR[ADDR_LSB-1:0];
        end else begin : g_noalign
            assign misal = 1'b0;
        end
    endgenerate

    assign bus_err = misal || ({1'b0, bus_idx} >= NREGS_L);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        leave      = 1'b0;
        commit     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WS_L;
                    end
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            RESP: begin
                if (!PSEL || PENABLE) begin
                    state_d = IDLE;
                    leave   = 1'b1;
                    commit  = PSEL && write_q && !err_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Zero-wait reads decode straight off the bus; otherwise use the capture.
    always_comb begin
        if (state_q == IDLE) begin
            sel_idx   = bus_idx[REG_IW-1:0];
            sel_err   = bus_err;
            sel_write = PWRITE;
        end else begin
            sel_idx   = idx_q;
            sel_err   = err_q;
            sel_write = write_q;
        end
        rd_val = '0;
        if (!sel_err && !sel_write) begin
            rd_val = regs[sel_idx];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            idx_q   <= '0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (accept) begin
            idx_q   <= bus_idx[REG_IW-1:0];
            err_q   <= bus_err;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else if (enter_resp) begin
            PREADY  <= 1'b1;
            PSLVERR <= sel_err;
            PRDATA  <= rd_val;
        end else if (leave) begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (commit) begin
            for (int l = 0; l < STRB_W; l++) begin
                if (strb_q[l]) begin
                    regs[idx_q][8*l +: 8] <= wdata_q[8*l +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: one completer with one wait state, one with three,
// sharing the bus except for PSEL.
`timescale 1ns/1ps
module tb_apb_slave_regfile;

    logic        pclk = 1'b0;
    logic        prstn;
    logic [7:0]  paddr;
    logic        psel1, psel3, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata1, prdata3;
    logic        pready1, pready3, pslverr1, pslverr3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 pclk = ~pclk;

    apb_slave_regfile #(.WAIT_STATES(1)) dut1 (
        .PCLK(pclk), .PRESETn(prstn), .PADDR(paddr), .PSEL(psel1),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PSTRB(pstrb), .PRDATA(prdata1), .PREADY(pready1),
        .PSLVERR(pslverr1)
    );

    apb_slave_regfile #(.WAIT_STATES(3)) dut3 (
        .PCLK(pclk), .PRESETn(prstn), .PADDR(paddr), .PSEL(psel3),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PSTRB(pstrb), .PRDATA(prdata3), .PREADY(pready3),
        .PSLVERR(pslverr3)
    );

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tv [12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Starts at posedge+1, returns at posedge+1 after the completion edge.
    task automatic xfer(input int which, input bit wr,
                        input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd,
                        output logic err, output int cyc);
        bit done;
        psel1   = (which == 1);
        psel3   = (which == 3);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        pstrb   = s;
        rd      = '0;
        err     = 1'b0;
        cyc     = 1;
        done    = 1'b0;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        paddr   = ~a;
        pwdata  = ~d;
        pstrb   = ~s;
        while (!done) begin
            @(negedge pclk);
            if ((which == 1) ? pready1 : pready3) begin
                rd   = (which == 1) ? prdata1 : prdata3;
                err  = (which == 1) ? pslverr1 : pslverr3;
                done = 1'b1;
            end else if (cyc >= 20) begin
                n_checks++;
                $display("FAIL timeout: addr %h got no PREADY want PREADY", a);
                done = 1'b1;
            end
            @(posedge pclk);
            #1;
            if (!done) cyc++;
        end
        psel1   = 1'b0;
        psel3   = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, rd2;
        logic        err, err2;
        int          cyc, cyc2;
        logic        seen;
        logic [31:0] exp1 [16];

        tv[0]  = '{0, 8'h00, 32'h0,        4'h0, 32'h0,        1'b0};
        tv[1]  = '{1, 8'h08, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        tv[2]  = '{0, 8'h08, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        tv[3]  = '{1, 8'h08, 32'h11223344, 4'h5, 32'h0,        1'b0};
        tv[4]  = '{0, 8'h08, 32'h0,        4'hF, 32'hDE22BE44, 1'b0};
        tv[5]  = '{1, 8'h00, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
        tv[6]  = '{1, 8'h40, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        tv[7]  = '{1, 8'h06, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        tv[8]  = '{0, 8'h40, 32'h0,        4'h0, 32'h0,        1'b1};
        tv[9]  = '{0, 8'h06, 32'h0,        4'h0, 32'h0,        1'b1};
        tv[10] = '{0, 8'h04, 32'h0,        4'h0, 32'h0,        1'b0};
        tv[11] = '{0, 8'h00, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};

        for (int i = 0; i < 16; i++) exp1[i] = 32'h0;
        exp1[0] = 32'hA5A5A5A5;
        exp1[2] = 32'hDE22BE44;

        prstn = 1'b0; psel1 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("rst_pready1", {31'b0, pready1}, 32'h0);
        chk("rst_pslverr1", {31'b0, pslverr1}, 32'h0);
        chk("rst_prdata1", prdata1, 32'h0);
        chk("rst_pready3", {31'b0, pready3}, 32'h0);
        @(posedge pclk);
        #1;
        prstn = 1'b1;
        @(posedge pclk);
        #1;

        for (int i = 0; i < 12; i++) begin
            xfer(1, tv[i].wr, tv[i].addr, tv[i].wdata, tv[i].strb,
                 rd, err, cyc);
            chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'b0, err},
                {31'b0, tv[i].exp_err});
            chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'd2);
        end

        for (int i = 0; i < 16; i++) begin
            xfer(1, 0, 8'(i * 4), 32'h0, 4'h0, rd, err, cyc);
            chk($sformatf("readback1_r%0d", i), rd, exp1[i]);
        end

        // PENABLE without a setup phase must not start a transfer.
        seen = 1'b0;
        psel1 = 1'b1; penable = 1'b1; pwrite = 1'b1;
        paddr = 8'h00; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        repeat (4) begin
            @(negedge pclk);
            seen |= pready1;
        end
        @(posedge pclk);
        #1;
        psel1 = 1'b0; penable = 1'b0;
        @(posedge pclk);
        #1;
        chk("no_setup_pready", {31'b0, seen}, 32'h0);
        xfer(1, 0, 8'h00, 32'h0, 4'h0, rd, err, cyc);
        chk("no_setup_reg0", rd, 32'hA5A5A5A5);

        xfer(1, 1, 8'h0C, 32'h0BADF00D, 4'hF, rd, err, cyc);
        xfer(1, 0, 8'h0C, 32'h0, 4'h0, rd2, err2, cyc2);
        chk("b2b_rdata", rd2, 32'h0BADF00D);
        chk("b2b_err", {30'b0, err, err2}, 32'h0);
        chk("b2b_occupancy", 32'(cyc + cyc2 + 2), 32'd6);

        xfer(3, 1, 8'h04, 32'hCAFEF00D, 4'hF, rd, err, cyc);
        chk("ws3_cycles", 32'(cyc), 32'd4);

        seen = 1'b0;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 8'h04; pwdata = 32'h12345678; pstrb = 4'hF;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        @(negedge pclk);
        seen |= pready3;
        @(posedge pclk);
        #1;
        psel3 = 1'b0; penable = 1'b0;
        repeat (5) begin
            @(negedge pclk);
            seen |= pready3;
        end
        @(posedge pclk);
        #1;
        chk("abort_pready", {31'b0, seen}, 32'h0);
        xfer(3, 0, 8'h04, 32'h0, 4'h0, rd, err, cyc);
        chk("abort_reg4", rd, 32'hCAFEF00D);
        chk("abort_read_cycles", 32'(cyc), 32'd4);

        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 8'h08; pwdata = 32'h77777777; pstrb = 4'hF;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        #2;
        prstn = 1'b0;
        #1;
        chk("midrst_pready3", {31'b0, pready3}, 32'h0);
        chk("midrst_pslverr3", {31'b0, pslverr3}, 32'h0);
        chk("midrst_prdata3", prdata3, 32'h0);
        chk("midrst_pready1", {31'b0, pready1}, 32'h0);
        psel3 = 1'b0; penable = 1'b0;
        @(posedge pclk);
        #1;
        prstn = 1'b1;
        @(posedge pclk);
        #1;

        for (int i = 0; i < 16; i++) begin
            xfer(1, 0, 8'(i * 4), 32'h0, 4'h0, rd, err, cyc);
            chk($sformatf("rst_readback1_r%0d", i), rd, 32'h0);
            xfer(3, 0, 8'(i * 4), 32'h0, 4'h0, rd, err, cyc);
            chk($sformatf("rst_readback3_r%0d", i), rd, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB4 completer (slave) that terminates the bus driven by the team's APB master. It holds a byte-strobed register file and inserts a parameterised number of wait states. It flags PSLVERR on bad addresses. It sits on the PADDR/PSEL/PENABLE/PWRITE/PWDATA/PSTRB → PRDATA/PREADY/PSLVERR side of the APB interface and serves as the bench's reference responder and the first real peripheral.

## Interface
- ADDR_WIDTH, 8: PADDR width (byte address).
- DATA_WIDTH, 32: PWDATA/PRDATA width; multiple of 8.
- NUM_REGS, 16: register count; 1..2^(ADDR_WIDTH-ADDR_LSB).
- WAIT_STATES, 1: wait cycles inserted per access; 0..15.
- ADDR_LSB (localparam): log2(DATA_WIDTH/8); 2 for 32-bit.
- PCLK  in  1  clock; all state updates on rising edge.
- PRESETn  in  1  reset; asynchronous, active-low.
- PADDR  in  ADDR_WIDTH  byte address.
- PSEL  in  1  select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte strobes.
- PRDATA  out  DATA_WIDTH  read data; registered.
- PREADY  out  1  transfer complete; registered.
- PSLVERR  out  1  error response; registered.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with PSEL=1, PENABLE=0 (setup), latch PADDR, PWRITE, PWDATA, PSTRB.
  - Decode error: err = (PADDR[ADDR_LSB-1:0] != 0) or (PADDR >> ADDR_LSB) >= NUM_REGS.
  - If WAIT_STATES=0: go to RESP. Otherwise load cnt=WAIT_STATES and go to WAIT.
- WAIT:
  - While PSEL=1, decrement cnt each edge.
  - When cnt=1, go to RESP.
  - If PSEL=0, abort to IDLE with no write.
- Entering RESP registers these outputs:
  - PREADY=1.
  - PSLVERR=err.
  - PRDATA = regs[idx] for a read with no error; otherwise 0.
- RESP: the edge with PSEL=1, PENABLE=1, PREADY=1 completes the transfer.
  - Write with no error: for each lane i with PSTRB[i]=1, regs[idx][8i+7:8i] ← PWDATA lane i (latched copy).
  - Error: write suppressed.
  - Go to IDLE and clear PREADY, PSLVERR and PRDATA to 0 at the same edge.
  - If PSEL=0 in RESP (master abort), go to IDLE, no write, outputs cleared.
- PSTRB is ignored on reads.
- Reads have no side effects.
- Register contents persist until written or reset.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - All regs=0, state=IDLE, cnt=0.
  - Reset mid-transfer drops the transfer; no partial write.
- Setup cycle T0, access phase starts T1:
  - PREADY goes high in cycle T1+WAIT_STATES.
  - Access phase lasts WAIT_STATES+1 cycles; a read with zero wait states takes 2 cycles total.
- Write data is visible to a read whose setup phase starts the cycle after completion.
- Back-to-back: a setup phase in the cycle immediately after completion is accepted (IDLE samples it); there are no dead cycles.
- PREADY is never high outside the final access cycle.
- PSLVERR and PRDATA are non-zero only while PREADY=1.
- PENABLE=1 sampled in IDLE without a prior setup is ignored.
- PADDR/PWDATA changes during WAIT/RESP are ignored (latched at setup).

## Test plan
- Reset, then read addr 0x00 with WAIT_STATES=1:
  - PREADY high exactly 2 cycles after setup.
  - PRDATA=0x00000000, PSLVERR=0.
- Write 0xDEADBEEF to 0x08 with PSTRB=0xF, then read 0x08:
  - Read returns 0xDEADBEEF, PSLVERR=0.
- Partial strobe: write 0x11223344 to 0x08 with PSTRB=0x5, then read 0x08:
  - Read returns 0xDE22BE44.
- Errors:
  - Write to 0x40 (idx 16 ≥ NUM_REGS): PSLVERR=1.
  - Write to 0x06 (unaligned): PSLVERR=1.
  - A full-register readback shows no register changed.
  - Read of 0x40: PRDATA=0, PSLVERR=1.
- Back-to-back: write 0x0C, then read 0x0C with the setup in the cycle after completion.
  - Read returns the written value.
  - Bus occupancy equals 2×(2+WAIT_STATES) cycles.
- Abort and reset:
  - WAIT_STATES=3: drop PSEL during WAIT on a write to 0x04. Reg 0x04 is unchanged and PREADY never rises.
  - Assert PRESETn=0 during WAIT of another write. All outputs are 0 immediately and all regs read back 0.
